vga_timing_gen: RTL and testbench

Parametrised VGA/SVGA raster timing generator. It produces sync, data-enable, blanking and visible-area pixel coordinates for any mode described by parameters, with programmable sync polarity. It also provides a pixel-clock enable, line/frame start strobes and a genlock-style restart. It sits between the pixel clock domain and the framebuffer/pixel pipeline, and drives the VGA connector syncs and the pixel-fetch logic.

---
 rtl/vga_pkg.sv | 45 ++++
 rtl/vga_axis_counter.sv | 71 +++++++
 rtl/vga_timing_gen.sv | 159 +++++++++++++++
 tb/tb_vga_timing_gen.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared raster timing types, standard mode tables and total-length helpers
// for the VGA timing generator and its per-axis counters.
package vga_pkg;

   typedef struct packed {
      int visible;
      int front;
      int sync;
      int back;
      bit pol;
   } axis_t;

   typedef struct packed {
      axis_t h;
      axis_t v;
   } mode_t;

   localparam mode_t VGA_640x480_60 = '{
      h: '{visible: 640, front: 16, sync: 96, back: 48, pol: 1'b0},
      v: '{visible: 480, front: 10, sync: 2, back: 33, pol: 1'b0}
   };

   localparam mode_t SVGA_800x600_60 = '{
      h: '{visible: 800, front: 40, sync: 128, back: 88, pol: 1'b1},
      v: '{visible: 600, front: 1, sync: 4, back: 23, pol: 1'b1}
   };

   localparam mode_t XGA_1024x768_60 = '{
      h: '{visible: 1024, front: 24, sync: 136, back: 160, pol: 1'b0},
      v: '{visible: 768, front: 3, sync: 6, back: 29, pol: 1'b0}
   };

   function automatic int axis_total(input axis_t a);
      return a.visible + a.front + a.sync + a.back;
   endfunction

   function automatic int h_total(input mode_t m);
      return axis_total(m.h);
   endfunction

   function automatic int v_total(input mode_t m);
      return axis_total(m.v);
   endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter plus sync/blank/first decode of
// the position currently being presented (forced to 0 while load_zero is high).
module vga_axis_counter
   import vga_pkg::*;
#(
   parameter int VISIBLE = 800,
   parameter int FRONT   = 40,
   parameter int SYNC    = 128,
   parameter int BACK    = 88,
   parameter bit POL     = 1'b1,
   parameter int W       = $clog2(VISIBLE + FRONT + SYNC + BACK)
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_step,
   input  logic         i_load_zero,
   output logic [W-1:0] o_count,
   output logic         o_wrap,
   output logic         o_sync,
   output logic         o_blank,
   output logic         o_first
);

   localparam axis_t C_AXIS = '{visible: VISIBLE, front: FRONT, sync: SYNC, back: BACK, pol: POL};
   localparam int TOTAL = axis_total(C_AXIS);

   if (VISIBLE < 1 || FRONT < 1 || SYNC < 1 || BACK < 1) begin : g_bad_timing
      $fatal(1, "vga_axis_counter: every timing parameter must be >= 1");
   end

   if (W < $clog2(TOTAL)) begin : g_bad_width
      $fatal(1, "vga_axis_counter: W too narrow for the axis total");
   end

   localparam logic [W-1:0] C_LAST       = W'(TOTAL - 1);
   localparam logic [W-1:0] C_VIS_END    = W'(VISIBLE);
   localparam logic [W-1:0] C_SYNC_START = W'(VISIBLE + FRONT);
   localparam logic [W-1:0] C_SYNC_END   = W'(VISIBLE + FRONT + SYNC);

   logic [W-1:0] r_count;
   logic [W-1:0] w_cur;
   logic [W-1:0] w_next;
   logic         w_in_sync;

   // A restart presents position 0 this cycle and advances from there.
   assign w_cur = i_load_zero ? '0 : r_count;

   always_comb begin
      w_next = w_cur;
      if (i_step) begin
         w_next = o_wrap ? '0 : w_cur + W'(1);
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_count <= '0;
      end else if (i_step || i_load_zero) begin
         r_count <= w_next;
      end
   end

   assign w_in_sync = (w_cur >= C_SYNC_START) && (w_cur < C_SYNC_END);

   assign o_count = w_cur;
   assign o_wrap  = (w_cur == C_LAST);
   assign o_sync  = w_in_sync ? POL : ~POL;
   assign o_blank = (w_cur >= C_VIS_END);
   assign o_first = (w_cur == '0);

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: registered syncs, blanking, DE,
// coordinates and line/frame strobes, with pixel enable and genlock restart.
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int H_VISIBLE  = 800,
   parameter int H_FRONT    = 40,
   parameter int H_SYNC     = 128,
   parameter int H_BACK     = 88,
   parameter int V_VISIBLE  = 600,
   parameter int V_FRONT    = 1,
   parameter int V_SYNC     = 4,
   parameter int V_BACK     = 23,
   parameter bit H_SYNC_POL = 1'b1,
   parameter bit V_SYNC_POL = 1'b1,
   parameter int H_W        = $clog2(H_VISIBLE + H_FRONT + H_SYNC + H_BACK),
   parameter int V_W        = $clog2(V_VISIBLE + V_FRONT + V_SYNC + V_BACK)
) (
   input  logic           i_clk,
   input  logic           i_rst_n,
   input  logic           i_ce,
   input  logic           i_restart,
   output logic           o_hsync,
   output logic           o_vsync,
   output logic           o_de,
   output logic           o_hblank,
   output logic           o_vblank,
   output logic [H_W-1:0] o_x,
   output logic [V_W-1:0] o_y,
   output logic           o_line_start,
   output logic           o_frame_start
);

   localparam mode_t C_MODE = '{
      h: '{visible: H_VISIBLE, front: H_FRONT, sync: H_SYNC, back: H_BACK, pol: H_SYNC_POL},
      v: '{visible: V_VISIBLE, front: V_FRONT, sync: V_SYNC, back: V_BACK, pol: V_SYNC_POL}
   };
   localparam int H_TOTAL = h_total(C_MODE);
   localparam int V_TOTAL = v_total(C_MODE);

   if (H_W < $clog2(H_TOTAL) || V_W < $clog2(V_TOTAL)) begin : g_bad_widths
      $fatal(1, "vga_timing_gen: H_W/V_W too narrow for the mode totals");
   end

   logic           r_restart_pend;
   logic           w_restart;
   logic           w_load_zero;
   logic [H_W-1:0] w_hcount;
   logic [V_W-1:0] w_vcount;
   logic           w_h_wrap;
   logic           w_v_wrap_unused;
   logic           w_hsync;
   logic           w_vsync;
   logic           w_hblank;
   logic           w_vblank;
   logic           w_hfirst;
   logic           w_vfirst;

   logic           r_hsync;
   logic           r_vsync;
   logic           r_de;
   logic           r_hblank;
   logic           r_vblank;
   logic [H_W-1:0] r_x;
   logic [V_W-1:0] r_y;
   logic           r_line_start;
   logic           r_frame_start;

   assign w_restart   = i_restart | r_restart_pend;
   assign w_load_zero = i_ce & w_restart;

   vga_axis_counter #(
      .VISIBLE (H_VISIBLE),
      .FRONT   (H_FRONT),
      .SYNC    (H_SYNC),
      .BACK    (H_BACK),
      .POL     (H_SYNC_POL),
      .W       (H_W)
   ) u_h_axis (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_step      (i_ce),
      .i_load_zero (w_load_zero),
      .o_count     (w_hcount),
      .o_wrap      (w_h_wrap),
      .o_sync      (w_hsync),
      .o_blank     (w_hblank),
      .o_first     (w_hfirst)
   );

   // The horizontal counter never reports a wrap while it is forced to 0,
   // so a restart also holds the vertical counter at line 0.
   vga_axis_counter #(
      .VISIBLE (V_VISIBLE),
      .FRONT   (V_FRONT),
      .SYNC    (V_SYNC),
      .BACK    (V_BACK),
      .POL     (V_SYNC_POL),
      .W       (V_W)
   ) u_v_axis (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_step      (i_ce & w_h_wrap),
      .i_load_zero (w_load_zero),
      .o_count     (w_vcount),
      .o_wrap      (w_v_wrap_unused),
      .o_sync      (w_vsync),
      .o_blank     (w_vblank),
      .o_first     (w_vfirst)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_restart_pend <= 1'b0;
      end else if (w_load_zero) begin
         r_restart_pend <= 1'b0;
      end else if (i_restart) begin
         r_restart_pend <= 1'b1;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_hsync       <= ~H_SYNC_POL;
         r_vsync       <= ~V_SYNC_POL;
         r_de          <= 1'b0;
         r_hblank      <= 1'b1;
         r_vblank      <= 1'b1;
         r_x           <= '0;
         r_y           <= '0;
         r_line_start  <= 1'b0;
         r_frame_start <= 1'b0;
      end else if (i_ce) begin
         r_hsync       <= w_hsync;
         r_vsync       <= w_vsync;
         r_de          <= ~w_hblank & ~w_vblank;
         r_hblank      <= w_hblank;
         r_vblank      <= w_vblank;
         r_x           <= w_hcount;
         r_y           <= w_vcount;
         r_line_start  <= w_hfirst;
         r_frame_start <= w_hfirst & w_vfirst;
      end else begin
         r_line_start  <= 1'b0;
         r_frame_start <= 1'b0;
      end
   end

   assign o_hsync       = r_hsync;
   assign o_vsync       = r_vsync;
   assign o_de          = r_de;
   assign o_hblank      = r_hblank;
   assign o_vblank      = r_vblank;
   assign o_x           = r_x;
   assign o_y           = r_y;
   assign o_line_start  = r_line_start;
   assign o_frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: small modes of both sync polarities,
// plus SVGA line/frame period measurement.
module tb_vga_timing_gen;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic ce = 1'b0;
   logic rs = 1'b0;

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Small mode H=8/2/3/1 (14), V=4/1/2/1 (8), active-high syncs.
   logic       s_hsync, s_vsync, s_de, s_hblank, s_vblank, s_line_start, s_frame_start;
   logic [3:0] s_x;
   logic [2:0] s_y;
   // Same mode, active-low syncs.
   logic       n_hsync, n_vsync, n_de, n_hblank, n_vblank, n_line_start, n_frame_start;
   logic [3:0] n_x;
   logic [2:0] n_y;
   // Small horizontal, SVGA vertical (frame = 628 lines).
   logic       v_line_start, v_frame_start;
   logic       v_hsync_unused, v_vsync_unused, v_de_unused, v_hblank_unused, v_vblank_unused;
   logic [3:0] v_x_unused;
   logic [9:0] v_y_unused;
   // Default SVGA (line = 1056 clocks).
   logic        d_line_start;
   logic        d_hsync_unused, d_vsync_unused, d_de_unused, d_hblank_unused, d_vblank_unused;
   logic        d_frame_start_unused;
   logic [10:0] d_x_unused;
   logic [9:0]  d_y_unused;

   vga_timing_gen #(
      .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(1),
      .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)
   ) dut_s (
      .i_clk(clk), .i_rst_n(rst_n), .i_ce(ce), .i_restart(rs),
      .o_hsync(s_hsync), .o_vsync(s_vsync), .o_de(s_de),
      .o_hblank(s_hblank), .o_vblank(s_vblank), .o_x(s_x), .o_y(s_y),
      .o_line_start(s_line_start), .o_frame_start(s_frame_start)
   );

   vga_timing_gen #(
      .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(1),
      .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
      .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b0)
   ) dut_n (
      .i_clk(clk), .i_rst_n(rst_n), .i_ce(ce), .i_restart(rs),
      .o_hsync(n_hsync), .o_vsync(n_vsync), .o_de(n_de),
      .o_hblank(n_hblank), .o_vblank(n_vblank), .o_x(n_x), .o_y(n_y),
      .o_line_start(n_line_start), .o_frame_start(n_frame_start)
   );

   vga_timing_gen #(
      .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(1)
   ) dut_v (
      .i_clk(clk), .i_rst_n(rst_n), .i_ce(ce), .i_restart(rs),
      .o_hsync(v_hsync_unused), .o_vsync(v_vsync_unused), .o_de(v_de_unused),
      .o_hblank(v_hblank_unused), .o_vblank(v_vblank_unused),
      .o_x(v_x_unused), .o_y(v_y_unused),
      .o_line_start(v_line_start), .o_frame_start(v_frame_start)
   );

   vga_timing_gen dut_d (
      .i_clk(clk), .i_rst_n(rst_n), .i_ce(ce), .i_restart(rs),
      .o_hsync(d_hsync_unused), .o_vsync(d_vsync_unused), .o_de(d_de_unused),
      .o_hblank(d_hblank_unused), .o_vblank(d_vblank_unused),
      .o_x(d_x_unused), .o_y(d_y_unused),
      .o_line_start(d_line_start), .o_frame_start(d_frame_start_unused)
   );

   // Vector layout: {hs, vs, de, hb, vb, ls, fs, x[3:0], y[2:0]}
   localparam logic [13:0] RESET_V  = 14'h0600;
   localparam logic [13:0] STROBES  = 14'h0180;
   localparam logic [13:0] SYNC_INV = 14'h3000;

   typedef struct {
      int          cyc;
      logic [13:0] v;
      string       name;
   } exp_t;

   exp_t q[$];
   int   q_lp[$];
   int   q_fl[$];

   int n_checks = 0;
   int n_pass   = 0;

   int          p = 0;
   bit          pend = 1'b0;
   bit          chk = 1'b1;
   bit          per_arm = 1'b0;
   logic [13:0] last = RESET_V;

   function automatic logic [13:0] pix(input int pp);
      int   x, y;
      logic hs, vs, hb, vb;
      x  = pp % 14;
      y  = (pp / 14) % 8;
      hs = (x >= 10 && x <= 12);
      vs = (y >= 5 && y <= 6);
      hb = (x >= 8);
      vb = (y >= 4);
      return {hs, vs, ~hb & ~vb, hb, vb, (x == 0), (x == 0 && y == 0), 4'(x), 3'(y)};
   endfunction

   task automatic chk_vec(input string name, input string which, input int c,
                          input logic [13:0] act, input logic [13:0] want);
      n_checks++;
      if (act === want) n_pass++;
      else $display("FAIL %s/%s cyc=%0d got=%h want=%h", name, which, c, act, want);
   endtask

   task automatic chk_int(input string name, input int act, input int want);
      n_checks++;
      if (act == want) n_pass++;
      else $display("FAIL %s got=%0d want=%0d", name, act, want);
   endtask

   task automatic push(input int c, input logic [13:0] v, input string name);
      exp_t t;
      if (chk) begin
         t.cyc  = c;
         t.v    = v;
         t.name = name;
         q.push_back(t);
      end
   endtask

   task automatic drive(input logic c_e, input logic r, input string name);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      ce    = c_e;
      rs    = r;
      if (c_e) begin
         if (r || pend) p = 0;
         pend = 1'b0;
         last = pix(p);
         p++;
      end else begin
         if (r) pend = 1'b1;
         last = last & ~STROBES;
      end
      push(cyc + 1, last, name);
   endtask

   task automatic reset_cycle(input string name);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      ce    = 1'b0;
      rs    = 1'b0;
      p     = 0;
      pend  = 1'b0;
      last  = RESET_V;
      push(cyc, RESET_V, name);
   endtask

   // Scoreboard monitor: pops an expectation when its cycle comes due.
   initial begin : mon
      exp_t me;
      forever begin
         @(negedge clk);
         while (q.size() > 0 && q[0].cyc <= cyc) begin
            me = q.pop_front();
            if (me.cyc < cyc) begin
               n_checks++;
               $display("FAIL %s missed cyc=%0d want=%h", me.name, me.cyc, me.v);
            end else begin
               chk_vec(me.name, "pos", cyc,
                       {s_hsync, s_vsync, s_de, s_hblank, s_vblank, s_line_start, s_frame_start, s_x, s_y},
                       me.v);
               chk_vec(me.name, "neg", cyc,
                       {n_hsync, n_vsync, n_de, n_hblank, n_vblank, n_line_start, n_frame_start, n_x, n_y},
                       me.v ^ SYNC_INV);
            end
         end
      end
   end

   // Period monitor: clocks between SVGA line strobes, lines between frame strobes.
   initial begin : per_mon
      int lp_prev;
      int fl_lines;
      bit fl_started;
      lp_prev    = -1;
      fl_lines   = 0;
      fl_started = 1'b0;
      forever begin
         @(negedge clk);
         if (per_arm) begin
            if (d_line_start) begin
               if (lp_prev >= 0 && q_lp.size() > 0) chk_int("line_period", cyc - lp_prev, q_lp.pop_front());
               lp_prev = cyc;
            end
            if (v_frame_start) begin
               if (fl_started && q_fl.size() > 0) chk_int("frame_lines", fl_lines, q_fl.pop_front());
               fl_started = 1'b1;
               fl_lines   = 1;
            end else if (v_line_start) begin
               fl_lines++;
            end
         end
      end
   end

   initial begin
      // Reset state.
      repeat (3) reset_cycle("reset");

      // Continuous pixel enable over two frames.
      repeat (230) drive(1'b1, 1'b0, "run");

      // Pixel enable toggling 1,0: outputs hold, strobes drop.
      repeat (30) begin
         drive(1'b1, 1'b0, "toggle");
         drive(1'b0, 1'b0, "toggle_hold");
      end

      // Restart requested at (5,2) during three idle clocks, with a duplicate pulse.
      while ((p % 112) != 34) drive(1'b1, 1'b0, "to_5_2");
      drive(1'b0, 1'b1, "rs_wait");
      drive(1'b0, 1'b0, "rs_wait");
      drive(1'b0, 1'b1, "rs_wait");
      drive(1'b1, 1'b0, "rs_first");
      repeat (20) drive(1'b1, 1'b0, "rs_run");
      drive(1'b1, 1'b1, "rs_same");
      repeat (20) drive(1'b1, 1'b0, "rs_run2");

      // Asynchronous reset at (6,1), with a restart left pending.
      while ((p % 112) != 21) drive(1'b1, 1'b0, "to_6_1");
      @(posedge clk);
      #1;
      ce = 1'b0;
      rs = 1'b1;
      repeat (3) reset_cycle("midreset");
      drive(1'b0, 1'b0, "rel_idle");
      drive(1'b0, 1'b0, "rel_idle");
      drive(1'b1, 1'b0, "rel_first");
      repeat (30) drive(1'b1, 1'b0, "rel_run");

      // SVGA timing periods after a restart aligns all instances.
      chk = 1'b0;
      repeat (4) q_lp.push_back(1056);
      repeat (2) q_fl.push_back(628);
      per_arm = 1'b1;
      drive(1'b1, 1'b1, "per_start");
      repeat (17700) drive(1'b1, 1'b0, "per_run");
      per_arm = 1'b0;
      repeat (2) @(posedge clk);

      while (q.size() > 0) begin
         n_checks++;
         $display("FAIL %s unchecked cyc=%0d want=%h", q[0].name, q[0].cyc, q[0].v);
         void'(q.pop_front());
      end
      while (q_lp.size() > 0) begin
         n_checks++;
         $display("FAIL line_period no strobe got=none want=%0d", q_lp.pop_front());
      end
      while (q_fl.size() > 0) begin
         n_checks++;
         $display("FAIL frame_lines no strobe got=none want=%0d", q_fl.pop_front());
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
